led_pattern_gen: RTL

//  Parametrised multi-channel LED pattern generator; next generation of the single-output flasher.

---
 rtl/led_pgen_pkg.sv | 29 ++
 rtl/led_pattern_gen_if.sv | 34 +++
 rtl/led_prescaler.sv | 42 ++++
 rtl/led_pattern_gen.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/led_pgen_pkg.sv
// ----------------------------------------------------------------------------
// led_pgen_pkg
// Shared types for the LED pattern generator: pattern modes, controller
// states and the bounce direction.
// Configuration macro: LED_PGEN_PWM_EN (nothing in this package depends on it).
// ----------------------------------------------------------------------------
package led_pgen_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        OFF    = 2'd0,
        BLINK  = 2'd1,
        CHASE  = 2'd2,
        BOUNCE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        RUN
    } state_e;

    typedef enum logic {
        LEFT,
        RIGHT
    } dir_e;

endpackage

// File: rtl/led_pattern_gen_if.sv
// ----------------------------------------------------------------------------
// led_pattern_gen_if
// Valid/ready configuration port of the LED pattern generator.
//   cfg_valid  master -> slave  config offer
//   cfg_ready  slave -> master  pending slot free
//   cfg_mode   master -> slave  OFF / BLINK / CHASE / BOUNCE
//   cfg_div    master -> slave  step period minus one
//   cfg_duty   master -> slave  brightness (only with LED_PGEN_PWM_EN)
// Configuration macro: LED_PGEN_PWM_EN adds cfg_duty.
// ----------------------------------------------------------------------------
interface led_pattern_gen_if #(
    parameter int CNT_W = 24,
    parameter int PWM_W = 4
);
    import led_pgen_pkg::*;

    typedef logic [PWM_W-1:0] duty_t;

    logic             cfg_valid;
    logic             cfg_ready;
    mode_e            cfg_mode;
    logic [CNT_W-1:0] cfg_div;

`ifdef LED_PGEN_PWM_EN
    duty_t            cfg_duty;

    modport master (output cfg_valid, cfg_mode, cfg_div, cfg_duty, input cfg_ready);
    modport slave  (input cfg_valid, cfg_mode, cfg_div, cfg_duty, output cfg_ready);
`else
    modport master (output cfg_valid, cfg_mode, cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, cfg_mode, cfg_div, output cfg_ready);
`endif

endinterface

// File: rtl/led_prescaler.sv
// ----------------------------------------------------------------------------
// led_prescaler
// Programmable step-rate divider. Counts enabled clocks and emits one tick
// per div+1 enabled cycles; div = 0 ticks on every enabled cycle.
//   clk   in         system clock
//   rst   in         synchronous active-high reset
//   en    in         count enable; while low the count holds and no tick fires
//   div   in  CNT_W  terminal count
//   clr   in         restart the period from zero (takes priority over en)
//   tick  out        high for the cycle in which cnt == div while enabled
// Configuration macro: LED_PGEN_PWM_EN (not used in this file).
// ----------------------------------------------------------------------------
module led_prescaler #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    input  logic             clr,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    // Tick is decoded from the registered count so it is a clean one-cycle
    // pulse that lines up with the wrap back to zero.
    assign tick = en && (cnt == div);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == div) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// ----------------------------------------------------------------------------
// led_pattern_gen
// Multi-channel LED pattern generator (off / blink / chase / bounce) stepped
// by a programmable prescaler. New mode and period arrive through a one-deep
// valid/ready slot and are committed only on a pattern-step boundary.
//   clk        in        system clock
//   rst        in        synchronous active-high reset
//   en         in        1 = run, 0 = freeze prescaler and pattern
//   cfg        slave     config port (led_pattern_gen_if)
//   led        out  CH   LED drive, active-high
//   step_tick  out       one-cycle pulse per pattern step
//   busy       out       high while a pattern is running
// Configuration macro: LED_PGEN_PWM_EN adds a brightness duty register and a
// free-running PWM counter that gates the whole pattern.
// ----------------------------------------------------------------------------
module led_pattern_gen
    import led_pgen_pkg::*;
#(
    parameter int CH      = 8,
    parameter int CNT_W   = 24,
    parameter int DIV_RST = 3,
    parameter int PWM_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    led_pattern_gen_if.slave  cfg,
    output logic [CH-1:0]     led,
    output logic              step_tick,
    output logic              busy
);

    typedef logic [PWM_W-1:0] duty_t;

    state_e           state;
    mode_e            mode;
    mode_e            pend_mode;
    dir_e             dir;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pend_div;
    logic             pend_valid;
    logic [CH-1:0]    pattern;
    logic             tick;
    logic             cfg_accept;

    function automatic logic [CH-1:0] start_pattern(input mode_e m);
        case (m)
            BLINK:         return '1;
            CHASE, BOUNCE: return CH'(1);
            default:       return '0;
        endcase
    endfunction

    assign cfg_accept    = cfg.cfg_valid && !pend_valid;
    assign cfg.cfg_ready = !pend_valid;
    assign busy          = (state == RUN);
    assign step_tick     = tick;

    // The APPLY cycle restarts the period so the new pattern gets a full
    // first step regardless of where the old period was.
    led_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .div  (div),
        .clr  (state == APPLY),
        .tick (tick)
    );

    // Controller: pending slot capture, state machine and pattern register.
    // A tick that finds a pending config goes to APPLY instead of stepping,
    // so a config accepted on a tick cycle still lets that tick step the old
    // pattern (pend_valid is only visible from the following cycle).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode       <= OFF;
            pend_mode  <= OFF;
            dir        <= LEFT;
            div        <= CNT_W'(DIV_RST);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            pattern    <= '0;
        end else begin
            if (cfg_accept) begin
                pend_valid <= 1'b1;
                pend_mode  <= cfg.cfg_mode;
                pend_div   <= cfg.cfg_div;
            end

            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        state <= APPLY;
                    end
                end

                APPLY: begin
                    mode       <= pend_mode;
                    div        <= pend_div;
                    dir        <= LEFT;
                    pattern    <= start_pattern(pend_mode);
                    pend_valid <= 1'b0;
                    state      <= (pend_mode == OFF) ? IDLE : RUN;
                end

                RUN: begin
                    if (tick) begin
                        if (pend_valid) begin
                            state <= APPLY;
                        end else begin
                            case (mode)
                                BLINK: pattern <= ~pattern;
                                // Rotate left; with CH == 1 this reduces to a hold.
                                CHASE: pattern <= (pattern << 1) | (pattern >> (CH - 1));
                                // The end bits reverse and move in the same step,
                                // so the lit LED never dwells at either end.
                                BOUNCE: begin
                                    if (CH > 1) begin
                                        if (dir == LEFT) begin
                                            if (pattern[CH-1]) begin
                                                pattern <= pattern >> 1;
                                                dir     <= RIGHT;
                                            end else begin
                                                pattern <= pattern << 1;
                                            end
                                        end else begin
                                            if (pattern[0]) begin
                                                pattern <= pattern << 1;
                                                dir     <= LEFT;
                                            end else begin
                                                pattern <= pattern >> 1;
                                            end
                                        end
                                    end
                                end
                                default: pattern <= pattern;
                            endcase
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef LED_PGEN_PWM_EN
    duty_t duty;
    duty_t pend_duty;
    duty_t pwm_cnt;
    logic  pwm_on;

    // Brightness: the duty rides in the same pending slot as mode/div and is
    // committed in APPLY; the PWM counter free-runs independently of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty      <= '1;
            pend_duty <= '1;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + duty_t'(1);
            if (cfg_accept) begin
                pend_duty <= cfg.cfg_duty;
            end
            if (state == APPLY) begin
                duty <= pend_duty;
            end
        end
    end

    // All-ones duty means fully on rather than on for 2^PWM_W - 1 cycles.
    assign pwm_on = (duty == '1) || (pwm_cnt < duty);
    assign led    = pattern & {CH{pwm_on}};
`else
    assign led = pattern;
`endif

endmodule
